// File: rtl/lsu_mem_master_pkg.sv
// Shared encodings for the load/store initiator: funct3 codes, store byte
// enables and the widths of the metadata and response records.
package lsu_mem_master_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  localparam int OFF_W = 2;

  // Response record: {data[31:0], tag, err}
  function automatic int resp_w(input int tag_w);
    return 32 + tag_w + 1;
  endfunction

  // Load metadata record: {tag, funct3, byte offset}
  function automatic int meta_w(input int tag_w);
    return tag_w + 3 + OFF_W;
  endfunction

endpackage

// File: rtl/lsu_mem_master_sync_fifo.sv
// Single-clock FIFO with occupancy count; storage is not reset, only the
// pointers and count are.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for data-memory port B: store lane formation,
// credit-tracked loads and in-order, extended load/error responses.
module lsu_mem_master
  import lsu_mem_master_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_err,
  output logic             mem_en,
  output logic [3:0]       mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_din,
  input  logic [31:0]      mem_dout,
  input  logic             mem_rvalid,
  input  logic             mem_accept_read,
  input  logic             mem_accept_write
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int MW = meta_w(TAG_W);
  localparam int RW = resp_w(TAG_W);

  funct3_e          f3;
  logic [1:0]       off;
  logic             legal;
  logic             acc;
  logic             issue_ld;
  logic             err_push;
  logic             ld_push;
  logic [3:0]       be;
  logic [31:0]      din_rep;
  logic [CW-1:0]    meta_count;
  logic [CW-1:0]    resp_count;
  logic [CW-1:0]    credit;
  logic             meta_full, meta_empty;
  logic             resp_full, resp_empty;
  logic [MW-1:0]    meta_din, meta_dout;
  logic [RW-1:0]    resp_din, resp_dout;
  logic [31:0]      ld_data_p0;

  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input funct3_e    f,
                                              input logic [1:0] o);
    logic [31:0]        sh;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic [31:0]        res;
    sh  = word >> {o, 3'b000};
    b_s = sh[7:0];
    h_s = sh[15:0];
    case (f)
      F3_B:    res = 32'(b_s);
      F3_H:    res = 32'(h_s);
      F3_BU:   res = {24'b0, sh[7:0]};
      F3_HU:   res = {16'b0, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  assign f3  = funct3_e'(req_funct3);
  assign off = req_addr[1:0];

  always_comb begin
    legal = 1'b0;
    case (f3)
      F3_B:    legal = 1'b1;
      F3_H:    legal = ~off[0];
      F3_W:    legal = (off == 2'b00);
      F3_BU:   legal = ~req_we;
      F3_HU:   legal = ~req_we & ~off[0];
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    be      = BE_W;
    din_rep = req_wdata;
    case (f3)
      F3_B: begin
        be      = BE_B << off;
        din_rep = {4{req_wdata[7:0]}};
      end
      F3_H: begin
        be      = BE_H << off;
        din_rep = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Credit covers reads in flight plus buffered responses, so the response
  // FIFO always has room when read data returns.
  assign credit = meta_count + resp_count;

  // Illegal requests wait for an idle block so their error stays in order.
  always_comb begin
    req_ready = 1'b0;
    if (!rst) begin
      if (!legal)      req_ready = (credit == '0) && resp_empty;
      else if (req_we) req_ready = mem_accept_write;
      else             req_ready = mem_accept_read && (credit < CW'(DEPTH)) && !meta_full;
    end
  end

  assign acc      = req_valid & req_ready;
  assign mem_en   = acc & legal;
  assign mem_we   = (mem_en & req_we) ? be : 4'b0000;
  assign mem_addr = {2'b00, req_addr[31:2]};
  assign mem_din  = din_rep;
  assign issue_ld = mem_en & ~req_we;
  assign err_push = acc & ~legal;
  assign ld_push  = mem_rvalid & ~meta_empty & ~resp_full;
  assign meta_din = {req_tag, req_funct3, off};

  sync_fifo #(.WIDTH(MW), .DEPTH(DEPTH)) u_meta_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (issue_ld),
    .din   (meta_din),
    .pop   (ld_push),
    .dout  (meta_dout),
    .full  (meta_full),
    .empty (meta_empty),
    .count (meta_count)
  );

  assign ld_data_p0 = extend_load(mem_dout, funct3_e'(meta_dout[OFF_W +: 3]),
                                  meta_dout[OFF_W-1:0]);

  assign resp_din = err_push ? {32'b0, req_tag, 1'b1}
                             : {ld_data_p0, meta_dout[MW-1 -: TAG_W], 1'b0};

  // Stage boundary: response FIFO registers extended data for the consumer.
  sync_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_resp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (err_push | ld_push),
    .din   (resp_din),
    .pop   (resp_valid & resp_ready),
    .dout  (resp_dout),
    .full  (resp_full),
    .empty (resp_empty),
    .count (resp_count)
  );

  assign resp_valid = ~resp_empty;
  assign resp_data  = resp_valid ? resp_dout[RW-1 -: 32]  : 32'b0;
  assign resp_tag   = resp_valid ? resp_dout[TAG_W:1]     : '0;
  assign resp_err   = resp_valid ? resp_dout[0]           : 1'b0;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master with a fixed 3-cycle memory model.
module tb_lsu_mem_master;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req_valid, req_ready, req_we;
  logic [2:0]       req_funct3;
  logic [31:0]      req_addr, req_wdata;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid, resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             resp_err;
  logic             mem_en;
  logic [3:0]       mem_we;
  logic [31:0]      mem_addr, mem_din, mem_dout;
  logic             mem_rvalid, mem_accept_read, mem_accept_write;

  lsu_mem_master #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_rvalid(mem_rvalid),
    .mem_accept_read(mem_accept_read), .mem_accept_write(mem_accept_write)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Memory model: byte-enabled writes, reads return 3 cycles after issue.
  bit [31:0] memw [64];
  bit [31:0] rd_pipe [3];
  logic [2:0] rv_pipe = 3'b000;
  logic       stray_rv = 1'b0;

  assign mem_rvalid = rv_pipe[2] | stray_rv;
  assign mem_dout   = rd_pipe[2];

  always @(posedge clk) begin
    if (mem_en)
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) memw[mem_addr[5:0]][8*b +: 8] <= mem_din[8*b +: 8];
    rv_pipe    <= {rv_pipe[1:0], (mem_en && mem_we == 4'b0000)};
    rd_pipe[0] <= memw[mem_addr[5:0]];
    rd_pipe[1] <= rd_pipe[0];
    rd_pipe[2] <= rd_pipe[1];
  end

  // Reference model: byte-addressed memory and request semantics.
  bit [7:0] refm [256];

  function automatic bit ref_legal(input logic we, input logic [2:0] f, input logic [31:0] a);
    case (f)
      3'b000:  return 1'b1;
      3'b001:  return a[0] == 1'b0;
      3'b010:  return a[1:0] == 2'b00;
      3'b100:  return !we;
      3'b101:  return !we && a[0] == 1'b0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [31:0] addr);
    logic [7:0]  a;
    logic [7:0]  w0;
    logic [7:0]  bv;
    logic [15:0] hv;
    a  = addr[7:0];
    w0 = {a[7:2], 2'b00};
    bv = refm[a];
    hv = {refm[a + 8'd1], refm[a]};
    case (f)
      3'b000:  return {{24{bv[7]}}, bv};
      3'b001:  return {{16{hv[15]}}, hv};
      3'b100:  return {24'h0, bv};
      3'b101:  return {16'h0, hv};
      default: return {refm[w0 + 8'd3], refm[w0 + 8'd2], refm[w0 + 8'd1], refm[w0]};
    endcase
  endfunction

  task automatic ref_store(input logic [2:0] f, input logic [31:0] addr, input logic [31:0] wd);
    logic [7:0] a;
    a = addr[7:0];
    refm[a] = wd[7:0];
    if (f != 3'b000) refm[a + 8'd1] = wd[15:8];
    if (f == 3'b010) begin
      refm[a + 8'd2] = wd[23:16];
      refm[a + 8'd3] = wd[31:24];
    end
  endtask

  logic [37:0] sb [$];
  logic [37:0] exp_e;

  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (sb.size() == 0) check("unexpected_resp", 64'd1, 64'd0);
      else begin
        exp_e = sb.pop_front();
        check("resp", 64'({resp_data, resp_tag, resp_err}), 64'(exp_e));
      end
    end
  end

  logic        acc_en;
  logic [3:0]  acc_we;
  logic [31:0] acc_addr, acc_din;
  int          waited;

  task automatic drive(input logic we, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] tag);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f;
    req_addr   = a;
    req_wdata  = wd;
    req_tag    = tag;
  endtask

  task automatic wait_accept();
    bit done;
    done   = 1'b0;
    waited = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        done     = 1'b1;
        acc_en   = mem_en;
        acc_we   = mem_we;
        acc_addr = mem_addr;
        acc_din  = mem_din;
        if (!ref_legal(req_we, req_funct3, req_addr)) sb.push_back({32'h0, req_tag, 1'b1});
        else if (req_we) ref_store(req_funct3, req_addr, req_wdata);
        else sb.push_back({ref_load(req_funct3, req_addr), req_tag, 1'b0});
      end else waited++;
    end
    if (!done) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] tag);
    drive(we, f, a, wd, tag);
    wait_accept();
  endtask

  int lat;
  bit seen;
  int saw;

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; req_tag = '0;
    resp_ready = 1'b1; mem_accept_read = 1'b1; mem_accept_write = 1'b1;

    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", 64'({resp_valid, resp_data, resp_tag, resp_err, mem_en, mem_we}), 64'd0);
    rst = 1'b0;
    #1 check("idle_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    // SW then LW with latency measurement
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0);
    check("sw_we", 64'(acc_we), 64'hF);
    check("sw_addr", 64'(acc_addr), 64'd4);
    check("sw_din", 64'(acc_din), 64'hDEADBEEF);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 5'd1);
    check("lw_mem", 64'({acc_en, acc_we, acc_addr}), 64'({1'b1, 4'b0000, 32'd4}));
    lat = 1; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1; else lat++;
    end
    check("lw_latency", 64'(lat), 64'd4);
    @(posedge clk); #1;

    // SB then LB / LBU of the same byte
    issue(1'b1, 3'b000, 32'h13, 32'h00000080, 5'd0);
    check("sb_we", 64'(acc_we), 64'h8);
    check("sb_din", 64'(acc_din), 64'h80808080);
    issue(1'b0, 3'b000, 32'h13, 32'h0, 5'd2);
    issue(1'b0, 3'b100, 32'h13, 32'h0, 5'd3);
    repeat (8) @(posedge clk); #1;

    // Fill the credit window with responses held back
    issue(1'b1, 3'b010, 32'h14, 32'h12345678, 5'd0);
    issue(1'b1, 3'b001, 32'h1A, 32'h0000CAFE, 5'd0);
    check("sh_we", 64'(acc_we), 64'hC);
    check("sh_din", 64'(acc_din), 64'hCAFECAFE);
    resp_ready = 1'b0;
    for (int t = 1; t <= 4; t++) issue(1'b0, 3'b010, 32'(32'h10 + 4 * (t - 1)), 32'h0, 5'(t));
    drive(1'b0, 3'b001, 32'h1A, 32'h0, 5'd5);
    repeat (6) @(negedge clk);
    check("credit_stall", 64'({req_ready, mem_en}), 64'd0);
    check("head_resp", 64'({resp_valid, resp_tag}), 64'({1'b1, 5'd1}));
    @(posedge clk); #1 resp_ready = 1'b1;
    wait_accept();
    check("stall_released", 64'(waited > 0), 64'd1);
    repeat (12) @(posedge clk); #1;

    // Misaligned LH waits for an idle block and returns an error
    issue(1'b0, 3'b010, 32'h14, 32'h0, 5'd6);
    drive(1'b0, 3'b001, 32'h21, 32'h0, 5'd7);
    wait_accept();
    check("lh_no_mem", 64'({acc_en, acc_we}), 64'd0);
    check("lh_waited", 64'(waited >= 3), 64'd1);
    @(negedge clk);
    check("err_lat", 64'({resp_valid, resp_err, resp_tag}), 64'({1'b1, 1'b1, 5'd7}));
    @(posedge clk); #1;
    issue(1'b1, 3'b100, 32'h20, 32'h55, 5'd12);
    check("bad_store_no_mem", 64'({acc_en, acc_we}), 64'd0);
    repeat (4) @(posedge clk); #1;

    // Memory refuses reads, then writes, for a few cycles
    mem_accept_read = 1'b0;
    drive(1'b0, 3'b010, 32'h18, 32'h0, 5'd8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ar_stall", 64'({req_ready, mem_en}), 64'd0);
    end
    @(posedge clk); #1 mem_accept_read = 1'b1;
    wait_accept();
    check("ar_issue", 64'({acc_en, 32'(waited)}), 64'({1'b1, 32'd0}));
    mem_accept_write = 1'b0;
    drive(1'b1, 3'b010, 32'h20, 32'h11223344, 5'd0);
    repeat (2) @(negedge clk);
    check("aw_stall", 64'({req_ready, mem_en}), 64'd0);
    @(posedge clk); #1 mem_accept_write = 1'b1;
    wait_accept();
    check("aw_issue", 64'(acc_we), 64'hF);
    issue(1'b0, 3'b010, 32'h20, 32'h0, 5'd11);
    repeat (8) @(posedge clk); #1;

    // Reset with a buffered response and two reads in flight
    resp_ready = 1'b0;
    issue(1'b0, 3'b010, 32'h10, 32'h0, 5'd9);
    repeat (5) @(posedge clk); #1;
    issue(1'b0, 3'b010, 32'h14, 32'h0, 5'd10);
    issue(1'b0, 3'b010, 32'h18, 32'h0, 5'd11);
    check("pre_rst_valid", 64'(resp_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_outs", 64'({resp_valid, resp_data, resp_tag, resp_err, mem_en, mem_we}), 64'd0);
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    resp_ready = 1'b1;
    saw = 0;
    for (int i = 0; i < 10; i++) begin
      stray_rv = (i == 5);
      @(negedge clk);
      if (resp_valid) saw++;
      @(posedge clk); #1;
    end
    stray_rv = 1'b0;
    check("no_stray_resp", 64'(saw), 64'd0);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 5'd13);

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
    #1 check("drain", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
